scan_chain_receiver: RTL
========================

Name: scan_chain_receiver

Overview:
- Chip-side endpoint of the scan-chain link: samples the slow SCAN_CLK/SCAN_EN/SCAN_IN/SCAN_RESET wires produced by the scan-chain subsystem and rebuilds each ADDR_BITS+PAYLOAD_BITS frame.
- Presents each complete frame on a one-entry valid/ready output.
- Used as an on-FPGA loopback checker and as the bench model of the SCuM-V scan chain.
- All scan inputs are asynchronous to clk and are oversampled; the scan clock is never used as a clock.

Parameters:
- ADDR_BITS, 12: address field width.
- PAYLOAD_BITS, 160: payload field width.
- SYNC_STAGES, 2: synchronizer flops per scan input (minimum 2).
- Local values, not overridable:
  - FRAME_BITS = ADDR_BITS + PAYLOAD_BITS.
  - CNT_W = clog2(FRAME_BITS+2).

Ports:
- clk  in  1  system clock (100 MHz).
- n_reset  in  1  synchronous reset, active-low.
- scan_clk  in  1  async scan clock from the controller.
- scan_en  in  1  async frame enable; high for the whole frame.
- scan_in  in  1  async serial data.
- scan_reset  in  1  async; high discards the partial frame.
- frame_valid  out  1  a buffered frame is available.
- frame_ready  in  1  consumer accepts the frame.
- frame_addr  out  ADDR_BITS  address of the buffered frame.
- frame_payload  out  PAYLOAD_BITS  payload of the buffered frame.
- bit_count  out  CNT_W  bits shifted into the current frame.
- busy  out  1  FSM in SHIFT.
- err_length  out  1  one-cycle pulse: frame ended with count != FRAME_BITS.
- err_overflow  out  1  one-cycle pulse: good frame dropped because the buffer was full.

Behaviour:
- Reset (n_reset low at a clk edge):
  - All outputs 0, shift register 0, count 0, FSM in IDLE.
  - All synchronizer flops and edge-detect registers 0.
  - Applies mid-frame and mid-handshake; the buffered frame is discarded.
- Synchronization:
  - Each scan input passes through SYNC_STAGES flops, then one history flop (prev).
  - Edge detect: rise = sync & ~prev; fall = ~sync & prev.
  - Input-to-action latency is SYNC_STAGES+1 clk cycles.
- Shifting:
  - On a scan_clk rise while scan_en_sync=1 and scan_reset_sync=0: sr <= {sr[FRAME_BITS-2:0], scan_in_sync}.
  - Bits arrive MSB-first; the first bit received ends in sr[FRAME_BITS-1].
  - Count increments and saturates at FRAME_BITS+1.
  - Beyond FRAME_BITS bits, sr keeps the last FRAME_BITS bits received.
- Frame split: frame_addr = sr[ADDR_BITS-1:0]; frame_payload = sr[FRAME_BITS-1:ADDR_BITS]. Payload is sent first, address last.
- FSM:
  - IDLE -> SHIFT when scan_en_sync=1; count cleared on entry.
  - SHIFT -> IDLE on scan_en fall (end of frame).
  - SHIFT -> IDLE on scan_reset_sync=1 (abort): count <= 0, sr <= 0, no frame, no error.
  - While scan_reset_sync=1 in either state: count and sr held at 0 and scan_clk rises ignored. The FSM waits in IDLE until scan_reset_sync=0.
  - Scan_clk rises while scan_en_sync=0 are ignored.
- End of frame:
  - count == FRAME_BITS and buffer free, or frame_valid & frame_ready in the same cycle: load frame_addr/frame_payload; frame_valid=1 next cycle.
  - count == FRAME_BITS and buffer full with no accept: the new frame is dropped, err_overflow pulses, and the old frame is held.
  - count != FRAME_BITS (including 0 and saturated): err_length pulses; buffer unchanged.
- Output handshake:
  - A transfer occurs on a clk edge with frame_valid & frame_ready.
  - frame_valid clears the following cycle unless a new frame is loaded in the same cycle, in which case it stays 1.
  - frame_addr and frame_payload are stable while frame_valid=1 and not accepted.
- Simultaneous scan_en fall and scan_reset_sync rise: reset wins; the frame is discarded silently.
- busy = (state == SHIFT). bit_count is the live count.

Test Plan:
- Valid frame: shift payload=160'h0123_4567_89AB_CDEF_0011_2233_4455_6677_8899_AABB, then addr=12'h5A3, MSB-first, 172 bits at 1 kHz, frame_ready=1 -> frame_valid pulses once with exactly those values; err flags stay 0; bit_count reaches 172.
- Short/long frames: 171 bits, then 173 bits -> err_length pulses once for each; frame_valid never asserts; the 173-bit case holds the last 172 bits in sr with count saturated at 173.
- Backpressure: frame_ready=0, send frames A (addr 12'h001) and B (addr 12'h002) -> A held stable; err_overflow pulses at B's end; raising ready then accepts A only.
- Load during accept: frame_ready pulsed high in the exact cycle B's end is processed -> A transfers and B loads; frame_valid stays 1 continuously; no overflow.
- scan_reset after 80 bits, then a full 172-bit frame (addr 12'hFFF, payload all ones) -> no error from the aborted frame; second frame delivered correctly.
- n_reset low for 1 cycle mid-frame (bit 100) with frame_valid=1 -> all outputs 0 next cycle; the remainder of that frame yields err_length; the next full frame is accepted normally.

Source files
------------

// File: rtl/scan_chain_receiver.sv
// Oversampling receiver for the scan-chain link: rebuilds ADDR_BITS+PAYLOAD_BITS
// frames from asynchronous scan wires and holds each one in a single valid/ready slot.
module scan_chain_receiver #(
    parameter  int ADDR_BITS    = 12,
    parameter  int PAYLOAD_BITS = 160,
    parameter  int SYNC_STAGES  = 2,
    localparam int FRAME_BITS   = ADDR_BITS + PAYLOAD_BITS,
    localparam int CNT_W        = $clog2(FRAME_BITS + 2)
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    scan_clk,
    input  logic                    scan_en,
    input  logic                    scan_in,
    input  logic                    scan_reset,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [ADDR_BITS-1:0]    frame_addr,
    output logic [PAYLOAD_BITS-1:0] frame_payload,
    output logic [CNT_W-1:0]        bit_count,
    output logic                    busy,
    output logic                    err_length,
    output logic                    err_overflow
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_SAT) ? c : c + 1'b1;
    endfunction

    // Bit order in the synchronizer vector: {scan_reset, scan_in, scan_en, scan_clk}
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] synced;
    // History only for the edge-sensitive inputs; data and abort act on level.
    logic [1:0] prev;

    logic clk_rise, en_fall, en_s, in_s, rst_s;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev <= '0;
        end else begin
            sync_q[0] <= {scan_reset, scan_in, scan_en, scan_clk};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= synced[1:0];
        end
    end

    assign synced   = sync_q[SYNC_STAGES-1];
    assign clk_rise = synced[0] & ~prev[0];
    assign en_fall  = ~synced[1] & prev[1];
    assign en_s     = synced[1];
    assign in_s     = synced[2];
    assign rst_s    = synced[3];

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic                    load, len_err, ovf_err;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sr_d    = sr_q;
        load    = 1'b0;
        len_err = 1'b0;
        ovf_err = 1'b0;
        // Abort has priority over everything, including a coincident end of frame
        if (rst_s) begin
            state_d = IDLE;
            count_d = '0;
            sr_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_s) begin
                        state_d = SHIFT;
                        count_d = '0;
                    end
                end
                SHIFT: begin
                    if (en_fall) begin
                        state_d = IDLE;
                        if (count_q == CNT_FULL) begin
                            if (!frame_valid || frame_ready) load = 1'b1;
                            else ovf_err = 1'b1;
                        end else begin
                            len_err = 1'b1;
                        end
                    end else if (clk_rise && en_s) begin
                        sr_d    = {sr_q[FRAME_BITS-2:0], in_s};
                        count_d = sat_inc(count_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            sr_q          <= '0;
            frame_valid   <= 1'b0;
            frame_addr    <= '0;
            frame_payload <= '0;
            err_length    <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            sr_q         <= sr_d;
            err_length   <= len_err;
            err_overflow <= ovf_err;
            if (load) begin
                frame_valid   <= 1'b1;
                frame_addr    <= sr_q[ADDR_BITS-1:0];
                frame_payload <= sr_q[FRAME_BITS-1:ADDR_BITS];
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

    assign busy      = (state_q == SHIFT);
    assign bit_count = count_q;

endmodule
